// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch scheduler: FSM state encoding,
// config register addresses and the ARMED timeout length.
package glitch_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_REP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } sched_state_t;

    localparam logic [1:0] CFG_DELAY  = 2'd0;
    localparam logic [1:0] CFG_WIDTH  = 2'd1;
    localparam logic [1:0] CFG_GAP    = 2'd2;
    localparam logic [1:0] CFG_REPEAT = 2'd3;

    // ARMED timeout length, 2^CNT_W-1 cycles for the default counter width.
    localparam int unsigned TIMEOUT_CYCLES = (32'd1 << DEF_CNT_W) - 32'd1;

endpackage

// File: rtl/glitch_sched_if.sv
// Command-layer <-> scheduler bundle: config writes, arm/abort/trigger in,
// glitch enable and status out.
interface glitch_sched_if
    import glitch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic             arm;
    logic             abort;
    logic             trigger;
    logic             glitch_en;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] attempts;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, arm, abort, trigger,
        input  glitch_en, busy, done, attempts
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, arm, abort, trigger,
        output glitch_en, busy, done, attempts
    );

endinterface

// File: rtl/glitch_cfg_regs.sv
// Timing parameter registers for the glitch scheduler. Writes land only while
// the scheduler is idle, so a running sequence never sees a changed value.
module glitch_cfg_regs
    import glitch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic             i_idle,
    output logic [CNT_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_gap,
    output logic [REP_W-1:0] o_repeat
);

    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_repeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_repeat <= '0;
        end else if (i_we && i_idle) begin
            case (i_addr)
                CFG_DELAY:  r_delay  <= i_wdata;
                CFG_WIDTH:  r_width  <= i_wdata;
                CFG_GAP:    r_gap    <= i_wdata;
                CFG_REPEAT: r_repeat <= i_wdata[REP_W-1:0];
            endcase
        end
    end

    assign o_delay  = r_delay;
    assign o_width  = r_width;
    assign o_gap    = r_gap;
    assign o_repeat = r_repeat;

endmodule

// File: rtl/glitch_sched.sv
// Cycle-accurate glitch scheduler: arm, wait for a trigger edge, delay, then
// issue WIDTH-cycle pulses separated by gaps. GLITCH_SCHED_TIMEOUT_EN adds an ARMED timeout.
//
// state   | meaning
// IDLE    | waiting for arm; config writable
// ARMED   | waiting for a rising trigger edge
// DELAY   | counting down DELAY cycles after the edge
// PULSE   | glitch_en high for WIDTH cycles
// GAP     | glitch_en low for max(GAP,1) cycles between pulses
// DONE    | one-cycle done pulse, then IDLE
module glitch_sched
    import glitch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    glitch_sched_if.slave bus
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [REP_W-1:0] r_att;
    logic [REP_W-1:0] w_att_nxt;
    logic             r_trig_d;
    logic             r_glitch_en;
    logic             w_go_pulse;

    logic [CNT_W-1:0] w_delay;
    logic [CNT_W-1:0] w_width;
    logic [CNT_W-1:0] w_gap;
    logic [REP_W-1:0] w_repeat;
    logic [CNT_W-1:0] w_gap_eff;
    logic [REP_W-1:0] w_rep_eff;
    logic [REP_W-1:0] w_att_inc;
    logic             w_edge;
    logic             w_cnt_last;

    glitch_cfg_regs #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) u_cfg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (bus.cfg_we),
        .i_addr   (bus.cfg_addr),
        .i_wdata  (bus.cfg_wdata),
        .i_idle   (r_state == S_IDLE),
        .o_delay  (w_delay),
        .o_width  (w_width),
        .o_gap    (w_gap),
        .o_repeat (w_repeat)
    );

    assign w_gap_eff  = (w_gap == '0) ? CNT_W'(1) : w_gap;
    assign w_rep_eff  = (w_repeat == '0) ? REP_W'(1) : w_repeat;
    assign w_att_inc  = (r_att == '1) ? r_att : r_att + REP_W'(1);
    assign w_edge     = bus.trigger && !r_trig_d;
    assign w_cnt_last = (r_cnt <= CNT_W'(1));

`ifdef GLITCH_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmo <= CNT_W'(TIMEOUT_CYCLES);
        end else if (r_state == S_ARMED && r_tmo != '0) begin
            r_tmo <= r_tmo - CNT_W'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_att_nxt   = r_att;
        w_go_pulse  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.arm) begin
                    w_state_nxt = S_ARMED;
                    w_att_nxt   = '0;
                end
            end
            S_ARMED: begin
                if (w_edge) begin
                    if (w_delay == '0) begin
                        w_go_pulse = 1'b1;
                    end else begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = w_delay;
                    end
                end
`ifdef GLITCH_SCHED_TIMEOUT_EN
                else if (r_tmo == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_att_nxt   = '0;
                end
`endif
            end
            S_DELAY: begin
                if (w_cnt_last) w_go_pulse = 1'b1;
            end
            S_PULSE: begin
                if (w_cnt_last) begin
                    if (r_att < w_rep_eff) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = w_gap_eff;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (w_cnt_last) w_go_pulse = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Zero width: skip the pulses but report the full repeat count.
        if (w_go_pulse) begin
            if (w_width == '0) begin
                w_state_nxt = S_DONE;
                w_att_nxt   = w_rep_eff;
            end else begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = w_width;
                w_att_nxt   = w_att_inc;
            end
        end

        if (bus.abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_att_nxt   = r_att;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_att       <= '0;
            r_trig_d    <= 1'b0;
            r_glitch_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_att       <= w_att_nxt;
            r_trig_d    <= bus.trigger;
            r_glitch_en <= (w_state_nxt == S_PULSE);
        end
    end

    assign bus.glitch_en = r_glitch_en;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.attempts  = r_att;

endmodule

// File: tb/tb_glitch_sched.sv
// Directed scoreboard bench for glitch_sched: expected pulses and done events
// are derived from the timing rules when the trigger is driven.
module tb_glitch_sched;
    import glitch_pkg::*;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    ev_t exp_p[$];
    ev_t exp_d[$];

    glitch_sched_if #(.CNT_W(16), .REP_W(8)) bus ();

    glitch_sched #(.CNT_W(16), .REP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = 16'(data);
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    // Push the pulses and done event implied by a trigger edge sampled in cycle t.
    task automatic expect_seq(input int t, input int d, input int w, input int g, input int r);
        int geff;
        int reff;
        geff = (g == 0) ? 1 : g;
        reff = (r == 0) ? 1 : r;
        if (w == 0) begin
            exp_d.push_back('{t + 1 + d, reff});
        end else begin
            for (int k = 0; k < reff; k++)
                exp_p.push_back('{t + 1 + d + k * (w + geff), w});
            exp_d.push_back('{t + d + reff * w + (reff - 1) * geff + 1, reff});
        end
    endtask

    task automatic fire(input int d, input int w, input int g, input int r);
        bus.trigger = 1'b1;
        expect_seq(cyc, d, w, g, r);
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_p.size() == 0 && exp_d.size() == 0) break;
            tick();
        end
        chk({tag, "_pulses_left"}, exp_p.size(), 0);
        chk({tag, "_done_left"}, exp_d.size(), 0);
        tick();
    endtask

    // Output monitor: every observed pulse and done must match a queued expectation.
    logic ge_prev = 1'b0;
    int   ge_start = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.glitch_en && !ge_prev) ge_start = cyc;
            if (!bus.glitch_en && ge_prev) begin
                chk("pulse_expected", exp_p.size() != 0, 1);
                if (exp_p.size() != 0) begin
                    ev_t e;
                    e = exp_p.pop_front();
                    chk("pulse_start", ge_start, e.cyc);
                    chk("pulse_width", cyc - ge_start, e.val);
                end
            end
            if (bus.done) begin
                chk("done_expected", exp_d.size() != 0, 1);
                chk("done_busy", bus.busy, 1);
                if (exp_d.size() != 0) begin
                    ev_t e;
                    e = exp_d.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_attempts", bus.attempts, e.val);
                end
            end
        end
        ge_prev = bus.glitch_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.trigger   = 1'b0;

        tick();
        tick();
        chk("rst_glitch_en", bus.glitch_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_attempts", bus.attempts, 0);
        rst_n = 1'b1;
        tick();

        // Single pulse: DELAY=3 WIDTH=2 REPEAT=1.
        cfg_write(CFG_DELAY, 3);
        cfg_write(CFG_WIDTH, 2);
        cfg_write(CFG_GAP, 0);
        cfg_write(CFG_REPEAT, 1);
        chk("idle_busy", bus.busy, 0);
        do_arm();
        chk("arm_busy", bus.busy, 1);
        tick();
        fire(3, 2, 0, 1);
        drain("single");
        chk("single_attempts", bus.attempts, 1);
        chk("single_busy_low", bus.busy, 0);

        // Repeated pulses: DELAY=0 WIDTH=1 GAP=2 REPEAT=3.
        cfg_write(CFG_DELAY, 0);
        cfg_write(CFG_WIDTH, 1);
        cfg_write(CFG_GAP, 2);
        cfg_write(CFG_REPEAT, 3);
        do_arm();
        chk("rep_attempts_cleared", bus.attempts, 0);
        fire(0, 1, 2, 3);
        drain("repeat");
        chk("repeat_attempts", bus.attempts, 3);

        // Trigger already high before arm must not fire.
        cfg_write(CFG_DELAY, 1);
        cfg_write(CFG_WIDTH, 2);
        cfg_write(CFG_REPEAT, 1);
        bus.trigger = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        do_arm();
        for (int i = 0; i < 4; i++) tick();
        chk("held_no_fire", bus.glitch_en, 0);
        chk("held_still_armed", bus.busy, 1);
        bus.trigger = 1'b0;
        tick();
        tick();
        fire(1, 2, 0, 1);
        drain("held");

        // Zero width: no pulse, done with attempts = REPEAT.
        cfg_write(CFG_WIDTH, 0);
        cfg_write(CFG_REPEAT, 2);
        do_arm();
        fire(1, 0, 2, 2);
        drain("zero_w");
        chk("zero_w_attempts", bus.attempts, 2);

        // Abort in the second pulse; DELAY write during the run is ignored.
        cfg_write(CFG_DELAY, 2);
        cfg_write(CFG_WIDTH, 3);
        cfg_write(CFG_GAP, 2);
        cfg_write(CFG_REPEAT, 4);
        do_arm();
        cfg_write(CFG_DELAY, 7);
        t = cyc;
        bus.trigger = 1'b1;
        exp_p.push_back('{t + 3, 3});
        exp_p.push_back('{t + 8, 2});
        tick();
        bus.trigger = 1'b0;
        for (int i = 0; i < 50 && cyc < t + 9; i++) tick();
        chk("abort_in_pulse", bus.glitch_en, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_glitch_off", bus.glitch_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_attempts", bus.attempts, 2);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_pulses_left", exp_p.size(), 0);
        chk("abort_attempts_held", bus.attempts, 2);
        cfg_write(CFG_REPEAT, 1);
        do_arm();
        fire(2, 3, 2, 1);
        drain("delay_kept");

        // Reset mid-DELAY clears outputs at once and config returns to zero.
        cfg_write(CFG_DELAY, 20);
        cfg_write(CFG_WIDTH, 1);
        do_arm();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_glitch_en", bus.glitch_en, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_attempts", bus.attempts, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_arm();
        chk("post_rst_arm_busy", bus.busy, 1);
        fire(0, 0, 0, 0);
        drain("post_rst");
        chk("post_rst_attempts", bus.attempts, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
